i2c_master_byte_ctrl: RTL and testbench
=======================================

I2C_MASTER_BYTE_CTRL -- requirements
Module: i2c_master_byte_ctrl

Interface
REQ-001 The block SHALL have no parameters; command encodings SHALL come from i2c_master_defines.sv: I2C_CMD_NOP=4'b0000, START=4'b0001, STOP=4'b0010, WRITE=4'b0100, READ=4'b1000.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The port list SHALL be as follows:
- clk  in  1  system clock; all flops on its rising edge.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  core enable.
- start  in  1  host request: generate START before the byte.
- stop  in  1  host request: generate STOP after the byte, or alone.
- read  in  1  host request: read one byte.
- write  in  1  host request: write one byte.
- ack_in  in  1  ACK bit the master drives after a read (0=ACK, 1=NACK).
- din  in  8  byte to write.
- cmd_ack  out  1  one-cycle pulse: host command complete.
- ack_out  out  1  ACK bit sampled in the ACK slot.
- dout  out  8  received byte.
- arb_lost  out  1  one-cycle pulse: command aborted by arbitration loss.
- core_cmd  out  4  command to the bit controller.
- core_txd  out  1  bit to the bit controller (its din).
- core_ack  in  1  bit controller command-complete pulse.
- core_rxd  in  1  bit controller sampled bit (its dout).
- i2c_al  in  1  bit controller arbitration lost.

Function
REQ-004 go SHALL be (read | write | stop) & ~cmd_ack; start alone SHALL NOT be go; the host holds request bits until cmd_ack.
REQ-005 States SHALL be ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP; core_cmd changes only on a transition and is held until core_ack.
REQ-006 In ST_IDLE with go, the block SHALL load shift register sr<=din and bit counter cnt<=7, then take the first matching branch:
- start: go to ST_START, core_cmd=START.
- read: go to ST_READ, core_cmd=READ.
- write: go to ST_WRITE, core_cmd=WRITE.
- otherwise: go to ST_STOP, core_cmd=STOP.
REQ-007 In ST_START on core_ack, the block SHALL go to ST_READ (core_cmd=READ) if read is set, else to ST_WRITE (core_cmd=WRITE).
REQ-008 In ST_WRITE/ST_READ, core_txd SHALL equal sr[7].
REQ-009 On each core_ack in ST_WRITE/ST_READ, sr SHALL shift left with core_rxd into bit 0; cnt SHALL decrement by 1 (3-bit, no wrap beyond 0).
REQ-010 When core_ack arrives with cnt==0, the block SHALL go to ST_ACK:
- from ST_WRITE: core_cmd=READ.
- from ST_READ: core_cmd=WRITE with core_txd=ack_in.
REQ-011 In ST_ACK on core_ack, ack_out SHALL load core_rxd; then the block SHALL go to ST_STOP (core_cmd=STOP) if stop is set, else to ST_IDLE with core_cmd=NOP and cmd_ack=1 the next cycle.
REQ-012 In ST_STOP on core_ack, the block SHALL go to ST_IDLE with core_cmd=NOP and cmd_ack=1.
REQ-013 dout SHALL equal sr at all times; after a read it is valid in the cmd_ack cycle and held until the next go.
REQ-014 i2c_al=1 in any state SHALL force, next cycle: ST_IDLE, core_cmd=NOP, cmd_ack=0, arb_lost=1 for one cycle; sr, cnt and ack_out SHALL hold.
REQ-015 i2c_al SHALL take priority over a simultaneous core_ack.
REQ-016 ena=0 SHALL force ST_IDLE and core_cmd=NOP synchronously, with no cmd_ack and no arb_lost; go SHALL be ignored while ena=0.
REQ-017 core_ack in ST_IDLE SHALL be ignored.
REQ-018 Latency from the final core_ack to cmd_ack SHALL be exactly 1 clk.

Reset
REQ-019 When rst=1, the block SHALL asynchronously set state=ST_IDLE, core_cmd=NOP, core_txd=0, cmd_ack=0, ack_out=0, arb_lost=0, sr=8'h00 (dout=8'h00), cnt=0.
REQ-020 Reset mid-byte SHALL abort with no cmd_ack; on release the block SHALL be in ST_IDLE and accept go from the first clk.

Configuration
REQ-021 With I2C_NACK_STOP_EN defined, a NACK (core_rxd=1) in the ACK slot of a write SHALL force ST_STOP and a STOP command even when stop=0, with cmd_ack after the STOP completes and ack_out=1.
REQ-022 Without I2C_NACK_STOP_EN, STOP SHALL be issued only when stop=1.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- start+write, din=8'hA5, slave ACK: core_cmd is START, then 8 WRITE with core_txd 1,0,1,0,0,1,0,1, then READ; cmd_ack 1 clk after the 10th core_ack; ack_out=0.
- read+stop, ack_in=1, core_rxd stream 8'h3C: 8 READ, then WRITE with core_txd=1, then STOP; dout=8'h3C at cmd_ack.
- stop alone: a single STOP command and one cmd_ack; sr unchanged.
- i2c_al pulse in the 4th WRITE bit: next cycle core_cmd=NOP, arb_lost=1 for 1 clk, no cmd_ack; a following write din=8'h12 completes normally.
- write (stop=0), slave NACK: ack_out=1; STOP issued only with I2C_NACK_STOP_EN defined.
- rst asserted mid-READ, and ena=0 mid-write: outputs at reset/NOP values, no cmd_ack, restart succeeds.

Source files
------------

// File: rtl/i2c_master_byte_ctrl.sv
// I2C master byte controller: sequences START / 8 data bits / ACK slot / STOP
// commands to a bit-level controller on behalf of a host byte request.
// Optional feature macro: I2C_NACK_STOP_EN -- a slave NACK after a written
// byte forces a STOP even when the host did not request one.
module i2c_master_byte_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       arb_lost,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd,
  input  logic       i2c_al
);
  // Bit-controller command encodings (shared with i2c_master_defines.sv)
  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP
  } state_t;

  state_t     state, state_n;
  logic [7:0] sr, sr_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] cmd_n;
  logic       txd_n, cmd_ack_n, ack_out_n, arb_lost_n;
  logic       go, nack_stop;

  // cmd_ack in the feedback keeps a still-held request from relaunching
  // in the cycle the host is being told it is done.
  assign go   = (read | write | stop) & ~cmd_ack;
  assign dout = sr;

  // The host holds its request bits for the whole byte, so ~read marks a write.
`ifdef I2C_NACK_STOP_EN
  assign nack_stop = ~read & core_rxd;
`else
  assign nack_stop = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sr       <= 8'h00;
      cnt      <= 3'd0;
      core_cmd <= I2C_CMD_NOP;
      core_txd <= 1'b0;
      cmd_ack  <= 1'b0;
      ack_out  <= 1'b0;
      arb_lost <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      cnt      <= cnt_n;
      core_cmd <= cmd_n;
      core_txd <= txd_n;
      cmd_ack  <= cmd_ack_n;
      ack_out  <= ack_out_n;
      arb_lost <= arb_lost_n;
    end
  end

  // Next-state and command sequencing; disable beats arbitration loss,
  // which beats a simultaneous core_ack.
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    cnt_n      = cnt;
    cmd_n      = core_cmd;
    txd_n      = core_txd;
    cmd_ack_n  = 1'b0;
    ack_out_n  = ack_out;
    arb_lost_n = 1'b0;
    if (!ena) begin
      state_n = ST_IDLE;
      cmd_n   = I2C_CMD_NOP;
    end else if (i2c_al) begin
      state_n    = ST_IDLE;
      cmd_n      = I2C_CMD_NOP;
      arb_lost_n = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          sr_n  = din;
          cnt_n = 3'd7;
          txd_n = din[7];
          if (start) begin
            state_n = ST_START; cmd_n = I2C_CMD_START;
          end else if (read) begin
            state_n = ST_READ;  cmd_n = I2C_CMD_READ;
          end else if (write) begin
            state_n = ST_WRITE; cmd_n = I2C_CMD_WRITE;
          end else begin
            state_n = ST_STOP;  cmd_n = I2C_CMD_STOP;
          end
        end
        ST_START: if (core_ack) begin
          txd_n = sr[7];
          if (read) begin
            state_n = ST_READ;  cmd_n = I2C_CMD_READ;
          end else begin
            state_n = ST_WRITE; cmd_n = I2C_CMD_WRITE;
          end
        end
        ST_WRITE, ST_READ: begin
          txd_n = sr[7];
          if (core_ack) begin
            sr_n  = {sr[6:0], core_rxd};
            txd_n = sr[6];
            if (cnt == 3'd0) begin
              state_n = ST_ACK;
              if (state == ST_READ) begin
                cmd_n = I2C_CMD_WRITE;
                txd_n = ack_in;
              end else begin
                cmd_n = I2C_CMD_READ;
              end
            end else begin
              cnt_n = cnt - 3'd1;
            end
          end
        end
        ST_ACK: if (core_ack) begin
          ack_out_n = core_rxd;
          if (stop | nack_stop) begin
            state_n = ST_STOP; cmd_n = I2C_CMD_STOP;
          end else begin
            state_n   = ST_IDLE; cmd_n = I2C_CMD_NOP;
            cmd_ack_n = 1'b1;
          end
        end
        ST_STOP: if (core_ack) begin
          state_n   = ST_IDLE; cmd_n = I2C_CMD_NOP;
          cmd_ack_n = 1'b1;
        end
        default: begin
          state_n = ST_IDLE; cmd_n = I2C_CMD_NOP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: a bit-controller stub answers each command
// after a random delay; a transaction-level model lists the command/txd/rxd
// sequence a host request should produce, plus final dout/ack_out.
`timescale 1ns/1ps
module tb_i2c_master_byte_ctrl;
  localparam logic [3:0] NOP = 4'b0000, STA = 4'b0001, STO = 4'b0010,
                         WR = 4'b0100, RD = 4'b1000;

  logic       clk = 1'b0;
  logic       rst, ena, start, stop, read, write, ack_in;
  logic [7:0] din, dout;
  logic       cmd_ack, ack_out, arb_lost, core_txd;
  logic [3:0] core_cmd;
  logic       core_ack, core_rxd, i2c_al;

  int total = 0, bad = 0;
  logic [7:0] exp_dout;
  logic       exp_ack_out;

  // Expected per-command sequence and observed sequence
  logic [3:0] e_cmd[$];
  logic       e_care[$], e_txd[$], e_rxd[$];
  logic [3:0] o_cmd[$];
  logic       o_txd[$];

  always #5 clk = ~clk;

  i2c_master_byte_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop),
    .read(read), .write(write), .ack_in(ack_in), .din(din),
    .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout), .arb_lost(arb_lost),
    .core_cmd(core_cmd), .core_txd(core_txd), .core_ack(core_ack),
    .core_rxd(core_rxd), .i2c_al(i2c_al)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic add(input logic [3:0] c, input logic care, input logic t, input logic r);
    e_cmd.push_back(c); e_care.push_back(care); e_txd.push_back(t); e_rxd.push_back(r);
  endtask

  task automatic drop_req();
    start = 0; stop = 0; read = 0; write = 0;
  endtask

  // One host request. abort_kind: 0 none, 1 arbitration loss, 2 ena low,
  // 3 reset -- applied instead of answering command number abort_at.
  task automatic xfer(input logic s, p, r, w, input logic [7:0] d, input logic ai,
                      input logic [7:0] rxb, input logic sa,
                      input int abort_at, input int abort_kind);
    int n = 0, last = 0, lat = -1, dly;
    logic done = 0, aborted = 0, al_seen = 0, nack_stop = 0, akb;
    logic [7:0] dout_at_ack = 8'h00;
    logic ack_at_ack = 0;
    logic [15:0] part;
    e_cmd.delete(); e_care.delete(); e_txd.delete(); e_rxd.delete();
    o_cmd.delete(); o_txd.delete();
`ifdef I2C_NACK_STOP_EN
    nack_stop = 1;
`endif
    akb = r ? ai : sa;
    if (!r && !w) add(STO, 0, 0, 1'($urandom));
    else begin
      if (s) add(STA, 0, 0, 1'($urandom));
      for (int k = 0; k < 8; k++) add(r ? RD : WR, 1, d[7-k], rxb[7-k]);
      add(r ? WR : RD, r, ai, akb);
      if (p || (nack_stop && !r && sa)) add(STO, 0, 0, 1'($urandom));
    end
    @(negedge clk);
    start = s; stop = p; read = r; write = w; din = d; ack_in = ai;
    dly = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 400 && !done && !aborted; cyc++) begin
      @(negedge clk);
      al_seen |= arb_lost;
      if (cmd_ack) begin
        done = 1; lat = cyc - last; core_ack = 0;
        dout_at_ack = dout; ack_at_ack = ack_out;
      end else if (core_ack) core_ack = 0;
      else if (core_cmd != NOP) begin
        if (dly > 0) dly--;
        else if (n == abort_at) begin
          aborted = 1;
          part = {d, rxb} << (n - (s ? 1 : 0));
          if (abort_kind == 1) begin
            i2c_al = 1; core_ack = 1; core_rxd = 1;
            @(negedge clk);
            i2c_al = 0; core_ack = 0;
            chk("al_cmd_nop", core_cmd, NOP);
            chk("al_pulse", arb_lost, 1);
            chk("al_no_cmd_ack", cmd_ack, 0);
            chk("al_sr_hold", dout, part[15:8]);
            chk("al_ack_out_hold", ack_out, exp_ack_out);
            drop_req();
            @(negedge clk);
            chk("al_pulse_end", arb_lost, 0);
            chk("al_no_cmd_ack2", cmd_ack, 0);
            exp_dout = part[15:8];
          end else if (abort_kind == 2) begin
            ena = 0;
            for (int i = 0; i < 3; i++) begin
              @(negedge clk);
              chk("ena_cmd_nop", core_cmd, NOP);
              chk("ena_no_cmd_ack", cmd_ack, 0);
              chk("ena_no_al", arb_lost, 0);
            end
            drop_req(); ena = 1;
            exp_dout = part[15:8];
          end else begin
            rst = 1; #1;
            chk("rst_cmd", core_cmd, NOP);
            chk("rst_txd", core_txd, 0);
            chk("rst_cmd_ack", cmd_ack, 0);
            chk("rst_ack_out", ack_out, 0);
            chk("rst_al", arb_lost, 0);
            chk("rst_dout", dout, 8'h00);
            drop_req();
            @(negedge clk); rst = 0;
            exp_dout = 8'h00; exp_ack_out = 0;
          end
        end else begin
          o_cmd.push_back(core_cmd); o_txd.push_back(core_txd);
          core_rxd = (n < e_rxd.size()) ? e_rxd[n] : 1'b0;
          core_ack = 1; last = cyc; n++;
          dly = $urandom_range(0, 3);
        end
      end
    end
    if (aborted) return;
    chk("cmd_ack_seen", done, 1);
    chk("n_cmds", o_cmd.size(), e_cmd.size());
    for (int i = 0; i < o_cmd.size() && i < e_cmd.size(); i++) begin
      chk($sformatf("cmd[%0d]", i), o_cmd[i], e_cmd[i]);
      if (e_care[i]) chk($sformatf("txd[%0d]", i), o_txd[i], e_txd[i]);
    end
    chk("cmd_ack_latency", lat, 1);
    if (r || w) begin exp_dout = rxb; exp_ack_out = akb; end
    chk("dout", dout_at_ack, exp_dout);
    chk("ack_out", ack_at_ack, exp_ack_out);
    chk("no_arb_lost", al_seen, 0);
    drop_req();
    @(negedge clk);
    chk("cmd_ack_one_cycle", cmd_ack, 0);
    chk("idle_nop", core_cmd, NOP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; ena = 1; i2c_al = 0; core_ack = 0; core_rxd = 0;
    ack_in = 0; din = 8'h00; drop_req();
    exp_dout = 8'h00; exp_ack_out = 0;
    #12;
    chk("reset_cmd", core_cmd, NOP);
    chk("reset_txd", core_txd, 0);
    chk("reset_cmd_ack", cmd_ack, 0);
    chk("reset_ack_out", ack_out, 0);
    chk("reset_al", arb_lost, 0);
    chk("reset_dout", dout, 8'h00);
    @(negedge clk); rst = 0;

    //   s  p  r  w  din    ai rxb    sa  abort
    xfer(1, 0, 0, 1, 8'hA5, 0, 8'hA5, 0, -1, 0); // start+write, slave ACK
    xfer(0, 1, 1, 0, 8'h00, 1, 8'h3C, 0, -1, 0); // read+stop, master NACK
    xfer(0, 1, 0, 0, exp_dout, 0, 8'h00, 0, -1, 0); // stop alone
    xfer(1, 0, 0, 1, 8'hC3, 0, 8'h5A, 0, 4, 1);  // arbitration loss in 4th bit
    xfer(0, 0, 0, 1, 8'h12, 0, 8'h12, 0, -1, 0); // recovery write
    xfer(0, 0, 0, 1, 8'h77, 0, 8'h77, 1, -1, 0); // write, slave NACK
    xfer(0, 0, 1, 0, 8'h00, 0, 8'h96, 0, 3, 3);  // reset mid-read
    xfer(0, 0, 1, 0, 8'h00, 0, 8'h4B, 0, -1, 0); // restart after reset
    xfer(0, 0, 0, 1, 8'hE1, 0, 8'hE1, 0, 2, 2);  // ena low mid-write
    xfer(1, 1, 0, 1, 8'h3D, 0, 8'h3D, 0, -1, 0); // restart after disable

    for (int t = 0; t < 40; t++) begin
      logic rr, ss, pp;
      rr = 1'($urandom); ss = 1'($urandom); pp = 1'($urandom);
      if ($urandom_range(0, 4) == 0)
        xfer(0, 1, 0, 0, exp_dout, 0, 8'h00, 0, -1, 0);
      else
        xfer(ss, pp, rr, ~rr, 8'($urandom), 1'($urandom), 8'($urandom),
             1'($urandom), -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
